// File: rtl/uart_bridge_pkg.sv
// Shared types and byte constants for the UART register bridge.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GET_ADDR = 2'd1,
    ST_GET_DATA = 2'd2,
    ST_SEND     = 2'd3
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  // Address byte selects an implemented register.
  function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned num_regs);
    return 32'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// FIFO-side handshake bundle between the bridge and the UART RX/TX FIFOs.
interface uart_reg_bridge_if;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       tx_full;

  modport master (input r_data, rx_empty, tx_full, output rd_uart, w_data, wr_uart);
  modport slave  (output r_data, rx_empty, tx_full, input rd_uart, w_data, wr_uart);
endinterface

// File: rtl/bridge_regfile.sv
// NUM_REGS x 8 register bank: one synchronous write port, one combinational read port.
module bridge_regfile #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [$clog2(NUM_REGS)-1:0]   waddr,
  input  logic [7:0]                    wdata,
  input  logic [$clog2(NUM_REGS)-1:0]   raddr,
  output logic [7:0]                    rdata,
  output logic [8*NUM_REGS-1:0]         regs_out
);

  logic [7:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[8*g +: 8] = mem[g];
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte command engine: pops W/R commands from the RX FIFO, executes them on the
// register bank and pushes one response byte per command into the TX FIFO.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_reg_bridge_if.master     fifo,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  busy
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    rsp_q, rsp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          timed_out;
  logic          pop, push, we;
  logic [7:0]    rdata;

  bridge_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (addr_q[AW-1:0]),
    .wdata    (fifo.r_data),
    .raddr    (fifo.r_data[AW-1:0]),
    .rdata    (rdata),
    .regs_out (regs_out)
  );

  // Waiting-cycle counter; a zero limit never matches so the wait is unbounded.
  assign cnt_inc   = cnt_q + CW'(1);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= 8'h00;
      rsp_q   <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    push    = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo.rx_empty) begin
          pop   = 1'b1;
          cnt_d = '0;
          if (fifo.r_data == CMD_WR || fifo.r_data == CMD_RD) begin
            is_wr_d = (fifo.r_data == CMD_WR);
            state_d = ST_GET_ADDR;
          end else begin
            rsp_d   = RSP_ERR;
            state_d = ST_SEND;
          end
        end
      end
      ST_GET_ADDR: begin
        if (!fifo.rx_empty) begin
          pop    = 1'b1;
          cnt_d  = '0;
          addr_d = fifo.r_data;
          if (is_wr_q) begin
            state_d = ST_GET_DATA;
          end else begin
            rsp_d   = addr_in_range(fifo.r_data, NUM_REGS) ? rdata : RSP_ERR;
            state_d = ST_SEND;
          end
        end else if (timed_out) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_GET_DATA: begin
        if (!fifo.rx_empty) begin
          pop     = 1'b1;
          cnt_d   = '0;
          we      = addr_in_range(addr_q, NUM_REGS);
          rsp_d   = we ? RSP_OK : RSP_ERR;
          state_d = ST_SEND;
        end else if (timed_out) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SEND: begin
        if (!fifo.tx_full) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are masked while reset is held so the FIFOs never see a pop/push then.
  assign fifo.rd_uart = pop & ~reset;
  assign fifo.wr_uart = push & ~reset;
  assign fifo.w_data  = rsp_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Randomised self-checking bench: FIFO models plus a command-level reference model.
module tb_uart_reg_bridge;

  localparam int unsigned NREG = 16;
  localparam int unsigned TO   = 100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [8*NREG-1:0] regs_out;
  logic              busy;

  uart_reg_bridge_if bus();

  uart_reg_bridge #(.NUM_REGS(NREG), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .fifo     (bus),
    .regs_out (regs_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         last_pop = 0;
  int         n_push = 0;
  logic [7:0] last_w = 8'h00;
  logic [7:0] rxq [$];
  logic [7:0] cur [$];
  logic [7:0] mregs [NREG];
  logic [7:0] exp_rsp = 8'h00;
  logic       pending = 1'b0;
  logic       txf_seen = 1'b0;
  logic       rd_seen = 1'b0;
  logic       skip_busy = 1'b0;
  logic       rand_txf = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8*NREG-1:0] model_vec();
    logic [8*NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[8*i +: 8] = mregs[i];
    return v;
  endfunction

  task automatic drive_rx();
    bus.rx_empty = (rxq.size() == 0);
    bus.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  task automatic enq(input logic [7:0] b);
    rxq.push_back(b);
    drive_rx();
  endtask

  task automatic finish_cmd(input logic [7:0] r);
    exp_rsp  = r;
    pending  = 1'b1;
    txf_seen = 1'b0;
    last_pop = cyc;
    cur.delete();
  endtask

  // Command-level model: parse the popped byte stream, predict responses and registers.
  task automatic model_check();
    logic [7:0] a;
    rd_seen = 1'b0;
    if (reset) begin
      chk("rst_rd_uart", 128'(bus.rd_uart), 128'(0));
      chk("rst_wr_uart", 128'(bus.wr_uart), 128'(0));
      chk("rst_w_data", 128'(bus.w_data), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
      cur.delete();
      pending = 1'b0;
      return;
    end
    chk("regs_out", regs_out, model_vec());
    if (!skip_busy) chk("busy", 128'(busy), 128'(pending || cur.size() != 0));
    if (pending && bus.tx_full) txf_seen = 1'b1;
    if (bus.rd_uart) begin
      chk("pop_when_empty", 128'(bus.rx_empty), 128'(0));
      chk("pop_during_send", 128'(pending), 128'(0));
      rd_seen = 1'b1;
      cur.push_back(bus.r_data);
      if (cur[0] != 8'h57 && cur[0] != 8'h52) begin
        finish_cmd(8'h3F);
      end else if (cur[0] == 8'h52 && cur.size() == 2) begin
        a = cur[1];
        finish_cmd((a < NREG) ? mregs[a[3:0]] : 8'h3F);
      end else if (cur[0] == 8'h57 && cur.size() == 3) begin
        a = cur[1];
        if (a < NREG) mregs[a[3:0]] = cur[2];
        finish_cmd((a < NREG) ? 8'h4B : 8'h3F);
      end
    end
    if (bus.wr_uart) begin
      chk("push_when_full", 128'(bus.tx_full), 128'(0));
      chk("push_unexpected", 128'(pending), 128'(1));
      chk("response", 128'(bus.w_data), 128'(exp_rsp));
      if (!txf_seen) chk("response_latency", 128'(cyc), 128'(last_pop + 1));
      pending = 1'b0;
      n_push++;
      last_w = bus.w_data;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_seen && rxq.size() != 0) void'(rxq.pop_front());
    if (rand_txf) bus.tx_full = ($urandom_range(0, 3) == 0);
    drive_rx();
  endtask

  task automatic wait_drain(input string name, input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (rxq.size() == 0 && !pending && cur.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) chk(name, 128'(0), 128'(1));
  endtask

  task automatic wait_rx_empty(input string name, input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (rxq.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) chk(name, 128'(0), 128'(1));
  endtask

  initial begin
    logic [8*NREG-1:0] v;
    logic [7:0]        b;
    int                p0;
    bus.tx_full = 1'b0;
    drive_rx();
    for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;

    repeat (3) step();
    reset = 1'b0;
    step();
    chk("post_reset_regs", regs_out, '0);
    chk("post_reset_busy", 128'(busy), 128'(0));
    chk("post_reset_w_data", 128'(bus.w_data), 128'(0));

    // Write 0xA5 to register 3.
    p0 = n_push;
    enq(8'h57); enq(8'h03); enq(8'hA5);
    wait_drain("drain_write", 50);
    v = '0;
    v[31:24] = 8'hA5;
    chk("write_push_count", 128'(n_push - p0), 128'(1));
    chk("write_ack", 128'(last_w), 128'(8'h4B));
    chk("write_regs", regs_out, v);

    enq(8'h52); enq(8'h03);
    wait_drain("drain_read3", 50);
    chk("read3", 128'(last_w), 128'(8'hA5));
    enq(8'h52); enq(8'h05);
    wait_drain("drain_read5", 50);
    chk("read5", 128'(last_w), 128'(8'h00));

    // Out-of-range write and unknown opcode.
    enq(8'h57); enq(8'h20); enq(8'h11);
    wait_drain("drain_oor", 50);
    chk("oor_rsp", 128'(last_w), 128'(8'h3F));
    chk("oor_regs", regs_out, v);
    enq(8'h41);
    wait_drain("drain_unknown", 50);
    chk("unknown_rsp", 128'(last_w), 128'(8'h3F));

    // TX back-pressure during a read response with a command queued behind it.
    p0 = n_push;
    bus.tx_full = 1'b1;
    enq(8'h52); enq(8'h03); enq(8'h41);
    repeat (50) step();
    chk("stall_no_push", 128'(n_push - p0), 128'(0));
    chk("stall_rx_left", 128'(rxq.size()), 128'(1));
    chk("stall_busy", 128'(busy), 128'(1));
    bus.tx_full = 1'b0;
    wait_drain("drain_stall", 50);
    chk("stall_push_count", 128'(n_push - p0), 128'(2));
    chk("stall_last", 128'(last_w), 128'(8'h3F));

    // Partial write abandoned by the timeout.
    p0 = n_push;
    enq(8'h57); enq(8'h02);
    wait_rx_empty("timeout_feed", 20);
    skip_busy = 1'b1;
    repeat (150) step();
    chk("timeout_idle", 128'(busy), 128'(0));
    chk("timeout_no_push", 128'(n_push - p0), 128'(0));
    skip_busy = 1'b0;
    cur.delete();
    enq(8'h52); enq(8'h02);
    wait_drain("drain_after_to", 50);
    chk("after_timeout_read", 128'(last_w), 128'(8'h00));

    // Reset between address and data of a write; orphan data byte becomes unknown.
    p0 = n_push;
    enq(8'h57); enq(8'h04);
    wait_rx_empty("reset_feed", 20);
    reset = 1'b1;
    repeat (3) step();
    chk("midreset_regs", regs_out, '0);
    chk("midreset_no_push", 128'(n_push - p0), 128'(0));
    reset = 1'b0;
    step();
    enq(8'hA5);
    wait_drain("drain_orphan", 50);
    chk("orphan_rsp", 128'(last_w), 128'(8'h3F));
    chk("orphan_regs", regs_out, '0);

    // Randomised command mix with random gaps and TX back-pressure.
    rand_txf = 1'b1;
    for (int c = 0; c < 300; c++) begin
      int kind;
      logic [7:0] cmd [$];
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        cmd.push_back(8'h57);
        cmd.push_back(8'($urandom_range(0, 19)));
        cmd.push_back(8'($urandom));
      end else if (kind < 9) begin
        cmd.push_back(8'h52);
        cmd.push_back(8'($urandom_range(0, 19)));
      end else begin
        do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
        cmd.push_back(b);
      end
      foreach (cmd[k]) begin
        enq(cmd[k]);
        repeat ($urandom_range(0, 4)) step();
      end
    end
    rand_txf = 1'b0;
    bus.tx_full = 1'b0;
    wait_drain("drain_random", 3000);
    chk("random_final_busy", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-level command engine sitting directly downstream of the UART receive FIFO and upstream of its transmit FIFO. Pops command bytes from the receive side, executes register write/read commands against an internal bank of 8-bit registers, and pushes one response byte per command into the transmit side. Register contents are exported in parallel so the rest of the design can use a serial link as its control/status port.

## Interface
- NUM_REGS, 16, number of 8-bit registers; a power of two, 2..256
- TIMEOUT_CYCLES, 1_000_000, maximum clk cycles to wait for the next byte of a partly received command; 0 disables the timeout
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- r_data  in  8  head byte of receive FIFO, valid whenever rx_empty=0
- rx_empty  in  1  receive FIFO empty
- rd_uart  out  1  one-cycle pop strobe to receive FIFO
- w_data  out  8  byte to push into transmit FIFO
- wr_uart  out  1  one-cycle push strobe to transmit FIFO
- tx_full  in  1  transmit FIFO full
- regs_out  out  8*NUM_REGS  register bank, register i on bits [8i+7:8i]
- busy  out  1  high in every state except IDLE

## Operation
- Protocol, byte-wise: write = 0x57 'W', addr, data -> response 0x4B 'K'; read = 0x52 'R', addr -> response = register value; any other first byte -> response 0x3F '?'.
- addr >= NUM_REGS -> no write, response 0x3F.
- States: IDLE, GET_ADDR, GET_DATA, SEND.
- IDLE: if rx_empty=0, pop byte. 'W' or 'R' -> latch opcode, GET_ADDR; other -> w_data_next=0x3F, SEND.
- GET_ADDR: on available byte, pop, latch addr. 'W' -> GET_DATA. 'R' -> response = reg[addr] (or 0x3F if out of range), SEND.
- GET_DATA: on available byte, pop; if in range, reg[addr] <= byte (visible on regs_out next cycle), response 0x4B; else 0x3F. -> SEND.
- SEND: wait for tx_full=0; then pulse wr_uart with w_data = response, -> IDLE.
- Timeout: cycle counter cleared on every pop and on entry to GET_ADDR/GET_DATA; counts while in those states with rx_empty=1; reaching TIMEOUT_CYCLES -> IDLE with no response and no write.
- Commands are processed strictly in order; no new byte is popped while in SEND.

## Timing
- Reset: state IDLE, rd_uart=0, wr_uart=0, w_data=0x00, busy=0, all registers 0x00, counter 0.
- Pop: rd_uart asserted combinationally in the same cycle the state sees rx_empty=0 in IDLE/GET_ADDR/GET_DATA; r_data sampled in that cycle; at most one pop per cycle, never when rx_empty=1.
- Push: wr_uart high exactly one cycle, only when tx_full=0, w_data stable during that cycle; never when tx_full=1.
- Latency with FIFOs non-blocking: write command last byte popped in cycle n -> wr_uart in cycle n+1; read likewise n+1; unknown byte popped in n -> push in n+1.
- Back-to-back commands: after a push in cycle m, next byte may be popped in m+1.
- Reset mid-command aborts it; partial writes never occur (register written only in GET_DATA pop cycle).
- Counter width $clog2(TIMEOUT_CYCLES+1); comparison exact equal, no wrap.

## Structure
- Shared package uart_bridge_pkg: state enum, opcode constants CMD_WR=0x57, CMD_RD=0x52, RSP_OK=0x4B, RSP_ERR=0x3F.
- One sub-module, bridge_regfile: NUM_REGS x 8 bank, one synchronous write port, one combinational read port, flattened regs_out, async reset to 0.
- Top holds FSM, timeout counter, response register.

## Test plan
- Reset, then bytes 0x57,0x03,0xA5 -> one wr_uart with 0x4B; regs_out[31:24]=0xA5; all other registers 0x00.
- After above, 0x52,0x03 -> w_data=0xA5; then 0x52,0x05 -> 0x00.
- 0x57,0x20,0x11 with NUM_REGS=16 -> response 0x3F, no register changes; single 0x41 -> 0x3F.
- tx_full held high 50 cycles during a read response -> wr_uart stays 0, no pops; release -> single push, then next queued command proceeds.
- TIMEOUT_CYCLES=100: send 0x57,0x02 then idle 150 cycles -> no response, state IDLE; following 0x52,0x02 -> 0x00.
- Assert reset between addr and data of a write -> outputs return to reset values, no write, no push.
